// File: rtl/universal_shift_reg.sv
// Universal WIDTH-bit shift register with complement output, seven data modes and
// an autonomous N-shift burst sequencer. Optional parity output via SHREG_PARITY_EN.
module universal_shift_reg #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter int               CNT_W     = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sin,
    input  logic             start,
    input  logic [CNT_W-1:0] count,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_n,
    output logic             sout,
    output logic             busy,
    output logic             done
`ifdef SHREG_PARITY_EN
    ,
    output logic             parity
`endif
);

    typedef enum logic [2:0] {
        MODE_HOLD  = 3'b000,
        MODE_LOAD  = 3'b001,
        MODE_SHL   = 3'b010,
        MODE_SHR   = 3'b011,
        MODE_ROTL  = 3'b100,
        MODE_ROTR  = 3'b101,
        MODE_ASR   = 3'b110,
        MODE_CLEAR = 3'b111
    } mode_e;

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } state_e;

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic             sout;
    } op_res_t;

    state_e           state_q, state_d;
    mode_e            mode_lat_q, mode_lat_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] qn_q;
    logic             sout_q, sout_d;
    logic             done_q, done_d;
    logic             accept;
    op_res_t          op_res;

    // sout only moves on shift/rotate modes; every other mode returns the old value.
    function automatic op_res_t apply_op(mode_e m, logic [WIDTH-1:0] cur,
                                         logic s_in, logic s_out);
        op_res_t r;
        r.data = cur;
        r.sout = s_out;
        case (m)
            MODE_LOAD:  r.data = d;
            MODE_SHL:   begin r.data = {cur[WIDTH-2:0], s_in};      r.sout = cur[WIDTH-1]; end
            MODE_SHR:   begin r.data = {s_in, cur[WIDTH-1:1]};      r.sout = cur[0];       end
            MODE_ROTL:  begin r.data = {cur[WIDTH-2:0], cur[WIDTH-1]}; r.sout = cur[WIDTH-1]; end
            MODE_ROTR:  begin r.data = {cur[0], cur[WIDTH-1:1]};    r.sout = cur[0];       end
            MODE_ASR:   begin r.data = {cur[WIDTH-1], cur[WIDTH-1:1]}; r.sout = cur[0];    end
            MODE_CLEAR: r.data = RESET_VAL;
            default:    r.data = cur;
        endcase
        return r;
    endfunction

    assign accept = (state_q == ST_IDLE) && start && (count != '0) &&
                    (mode inside {MODE_SHL, MODE_SHR, MODE_ROTL, MODE_ROTR, MODE_ASR});

    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        state_d    = state_q;
        mode_lat_d = mode_lat_q;
        cnt_d      = cnt_q;
        data_d     = data_q;
        sout_d     = sout_q;
        done_d     = 1'b0;
        op_res     = '{data: data_q, sout: sout_q};

        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d    = ST_RUN;
                    mode_lat_d = mode_e'(mode);
                    cnt_d      = count;
                end else if (en) begin
                    op_res = apply_op(mode_e'(mode), data_q, sin, sout_q);
                    data_d = op_res.data;
                    sout_d = op_res.sout;
                end
            end
            ST_RUN: begin
                if (en) begin
                    op_res = apply_op(mode_lat_q, data_q, sin, sout_q);
                    data_d = op_res.data;
                    sout_d = op_res.sout;
                    cnt_d  = cnt_q - 1'b1;
                    if (cnt_q == 1) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: registers update with non-blocking assignments so all flops sample together.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            mode_lat_q <= MODE_HOLD;
            cnt_q      <= '0;
            data_q     <= RESET_VAL;
            qn_q       <= ~RESET_VAL;
            sout_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_lat_q <= mode_lat_d;
            cnt_q      <= cnt_d;
            data_q     <= data_d;
            qn_q       <= ~data_d;
            sout_q     <= sout_d;
            done_q     <= done_d;
        end
    end

    assign q    = data_q;
    assign q_n  = qn_q;
    assign sout = sout_q;
    assign busy = (state_q == ST_RUN);
    assign done = done_q;

`ifdef SHREG_PARITY_EN
    logic parity_q;

    always_ff @(posedge clk) begin
        if (reset) parity_q <= ^RESET_VAL;
        else       parity_q <= ^data_d;
    end

    assign parity = parity_q;
`endif

endmodule

// File: tb/tb_universal_shift_reg.sv
// Directed self-checking bench for universal_shift_reg (WIDTH=8, RESET_VAL=8'hA5).
// Define SHREG_PARITY_EN for both files to exercise the parity output.
module tb_universal_shift_reg;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;
    localparam logic [2:0] HOLD = 3'b000, LOAD = 3'b001, SHL = 3'b010, SHR = 3'b011,
                           ROTL = 3'b100, ROTR = 3'b101, ASR = 3'b110, CLR = 3'b111;

    logic             clk = 1'b0;
    logic             reset, en, sin, start;
    logic [2:0]       mode;
    logic [WIDTH-1:0] d;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] q, q_n;
    logic             sout, busy, done;
`ifdef SHREG_PARITY_EN
    logic             parity;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    universal_shift_reg #(
        .WIDTH(WIDTH), .RESET_VAL(8'hA5), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .en(en), .mode(mode), .d(d), .sin(sin),
        .start(start), .count(count), .q(q), .q_n(q_n), .sout(sout),
        .busy(busy), .done(done)
`ifdef SHREG_PARITY_EN
        , .parity(parity)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; mode = HOLD; d = '0; sin = 1'b0; start = 1'b0; count = '0;
        tick();
        tick();
        reset = 1'b0;
        check("rst_q", q, 8'hA5);
        check("rst_qn", q_n, 8'h5A);
        check("rst_sout", sout, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);

        en = 1'b1; mode = LOAD; d = 8'h3C; tick();
        check("load_q", q, 8'h3C);
        check("load_qn", q_n, 8'hC3);

        d = 8'h81; tick();
        mode = SHL; sin = 1'b1; tick();
        check("shl_q", q, 8'h03);
        check("shl_sout", sout, 1'b1);

        mode = LOAD; d = 8'h80; tick();
        check("load_sout_hold", sout, 1'b1);
        mode = ASR; tick();
        check("asr_q", q, 8'hC0);
        check("asr_sout", sout, 1'b0);

        mode = LOAD; d = 8'h01; tick();
        mode = ROTR; tick();
        check("rotr_q", q, 8'h80);
        check("rotr_qn", q_n, 8'h7F);
        check("rotr_sout", sout, 1'b1);

        mode = SHR; sin = 1'b1; tick();
        check("shr_q", q, 8'hC0);
        check("shr_sout", sout, 1'b0);
        mode = ROTL; tick();
        check("rotl_q", q, 8'h81);
        check("rotl_sout", sout, 1'b1);

        mode = HOLD; tick();
        check("hold_q", q, 8'h81);
        mode = CLR; tick();
        check("clear_q", q, 8'hA5);
        check("clear_sout", sout, 1'b1);

        en = 1'b0; mode = SHL; sin = 1'b0; tick();
        check("en0_q", q, 8'hA5);
        check("en0_sout", sout, 1'b1);

        // Burst ROTL x3 on 01, mode/start wiggled during RUN
        en = 1'b1; mode = LOAD; d = 8'h01; tick();
        mode = ROTL; start = 1'b1; count = 4'd3; tick();
        check("bst_accept_q", q, 8'h01);
        check("bst_accept_busy", busy, 1'b1);
        mode = LOAD; d = 8'hFF; count = 4'd5; tick();
        check("bst1_q", q, 8'h02);
        check("bst1_busy", busy, 1'b1);
        check("bst1_done", done, 1'b0);
        mode = CLR; tick();
        check("bst2_q", q, 8'h04);
        check("bst2_busy", busy, 1'b1);
        mode = SHR; tick();
        check("bst3_q", q, 8'h08);
        check("bst3_busy", busy, 1'b0);
        check("bst3_done", done, 1'b1);
        check("bst3_sout", sout, 1'b0);
        start = 1'b0; mode = HOLD; tick();
        check("bst_after_done", done, 1'b0);
        check("bst_after_q", q, 8'h08);

        // Burst with a 2-cycle en gap, then a new start in the done cycle
        mode = LOAD; d = 8'h01; tick();
        mode = ROTL; start = 1'b1; count = 4'd3; tick();
        start = 1'b0; mode = HOLD; tick();
        check("gap1_q", q, 8'h02);
        en = 1'b0; tick();
        tick();
        check("gap_frozen_q", q, 8'h02);
        check("gap_busy", busy, 1'b1);
        check("gap_done", done, 1'b0);
        en = 1'b1; tick();
        check("gap2_q", q, 8'h04);
        check("gap2_done", done, 1'b0);
        tick();
        check("gap3_q", q, 8'h08);
        check("gap3_done", done, 1'b1);
        check("gap3_busy", busy, 1'b0);
        mode = SHR; sin = 1'b0; start = 1'b1; count = 4'd1; tick();
        check("rearm_busy", busy, 1'b1);
        check("rearm_done", done, 1'b0);
        check("rearm_q", q, 8'h08);
        start = 1'b0; mode = HOLD; tick();
        check("rearm_shift_q", q, 8'h04);
        check("rearm_end_done", done, 1'b1);
        tick();
        check("rearm_clear_done", done, 1'b0);

        // Ignored starts
        mode = LOAD; d = 8'h55; start = 1'b1; count = 4'd3; tick();
        check("ign_load_q", q, 8'h55);
        check("ign_load_busy", busy, 1'b0);
        mode = SHL; sin = 1'b0; count = 4'd0; tick();
        check("ign_cnt0_q", q, 8'hAA);
        check("ign_cnt0_busy", busy, 1'b0);
        check("ign_cnt0_sout", sout, 1'b0);

        // Reset in the middle of a burst
        mode = SHR; count = 4'd5; tick();
        check("mid_busy", busy, 1'b1);
        start = 1'b0; tick();
        check("mid_q", q, 8'h55);
        reset = 1'b1; tick();
        check("mrst_q", q, 8'hA5);
        check("mrst_qn", q_n, 8'h5A);
        check("mrst_busy", busy, 1'b0);
        check("mrst_sout", sout, 1'b0);
        reset = 1'b0; mode = HOLD; tick();
        check("mrst_after_q", q, 8'hA5);
        check("mrst_after_busy", busy, 1'b0);
        check("mrst_after_done", done, 1'b0);

`ifdef SHREG_PARITY_EN
        reset = 1'b1; tick();
        reset = 1'b0;
        check("par_rst", parity, 1'b0);
        mode = LOAD; d = 8'h07; tick();
        check("par_07", parity, 1'b1);
        d = 8'h03; tick();
        check("par_03", parity, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
